sram_wrapper_dff_rw_r: RTL and testbench
========================================

Name: sram_wrapper_dff_rw_r

Overview:
- Parametrised two-port memory wrapper built from banked single-port DFF RAM macros.
- Ports:
  - Primary RW port, usually owned by the core.
  - Secondary read-only port, usually owned by the Wishbone/debug side.
- Bank-conflict arbitration: primary has priority, bounded by a starvation guard; a one-entry pending buffer holds a deferred secondary read.
- Replaces the single-port DFF wrapper wherever a second reader is needed.

Parameters:
- BYTE_COUNT, 4: bytes per word; WORD_SIZE = 8*BYTE_COUNT.
- ADDRESS_SIZE, 9: word address width; must be >= BANK_ADDRESS_SIZE.
- BANK_ADDRESS_SIZE, 6: word address width of one macro; BANK_COUNT = 2^(ADDRESS_SIZE-BANK_ADDRESS_SIZE).
- STALL_LIMIT, 3: consecutive conflict losses before the secondary port is forced through; range 1..15.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous active-high reset.
- primarySelect  in  1  primary request.
- primaryWriteEnable  in  1  1 = write, 0 = read.
- primaryWriteMask  in  BYTE_COUNT  per-byte write enable.
- primaryAddress  in  ADDRESS_SIZE  word address.
- primaryDataWrite  in  WORD_SIZE  write data.
- primaryReady  out  1  primary request accepted this cycle.
- primaryDataRead  out  WORD_SIZE  read data, held until next primary read.
- primaryReadValid  out  1  one-cycle strobe: primaryDataRead updated.
- secondarySelect  in  1  secondary read request.
- secondaryAddress  in  ADDRESS_SIZE  word address.
- secondaryReady  out  1  secondary request accepted this cycle.
- secondaryDataRead  out  WORD_SIZE  read data, held until next secondary read.
- secondaryReadValid  out  1  one-cycle strobe.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0 except primaryReady = 1 and secondaryReady = 1. Pending buffer cleared, stall counter 0, in-flight reads discarded (no valid strobe after reset). Memory contents are not reset.
- Bank select: address[ADDRESS_SIZE-1:BANK_ADDRESS_SIZE]; each bank is one macro with one access per cycle.
- Secondary source: the pending entry if one exists, else the live secondarySelect/secondaryAddress. Conflict = primarySelect and secondary source present and both target the same bank.
- No conflict: both ports issue in the same cycle.
- Conflict with stallCount < STALL_LIMIT:
  - Primary issues.
  - A live secondary request is captured into pending (secondaryReady = 1 for that capture).
  - stallCount increments.
- Conflict with stallCount == STALL_LIMIT and pending valid:
  - primaryReady = 0; primary is not issued and must hold its request.
  - Pending issues; stallCount resets to 0.
- primaryReady = !(pendingValid && stallCount == STALL_LIMIT).
- secondaryReady = !pendingValid.
- stallCount resets to 0 whenever pending issues.
- Writes:
  - Bytes with mask bit = 1 are updated at the issuing posedge.
  - A mask of 0 makes the access a no-op, with no read strobe.
  - A write never produces a read strobe.
- Reads:
  - Data appears on the next posedge after issue; the matching ReadValid is high for exactly that cycle.
  - Read data is the word as it stands before any same-cycle write to it.
  - A deferred secondary read observes all primary writes issued before it.
- Back-to-back reads: one per cycle per port when there is no conflict.
- Out-of-range bank indices cannot occur because BANK_COUNT is a power of two.
- Reset asserted mid-operation takes priority over every other update in that cycle.

Optional Feature:
- SRAM_WRAPPER_OUTPUT_REG_EN defined:
  - Adds an output register stage to both ports; read latency becomes 2 cycles.
  - ReadValid is delayed by the same amount.
  - The stage is cleared by rst.
- Undefined: latency is 1 cycle as above.

Decomposition:
- Shared package holds:
  - WORD_SIZE and BANK_COUNT derivation functions.
  - The stall-counter width constant (4 bits).
  - The bank-index extraction function.
- Sub-module dff_ram_bank is the natural unit:
  - One macro: 2^BANK_ADDRESS_SIZE words, byte write enable, 1-cycle read.
  - Instantiated BANK_COUNT times in a generate loop.
  - Read-data muxing uses the bank index registered at issue.

Test Plan:
- Primary write 0xDEADBEEF to addr 0x005 with mask 0xF, then read addr 0x005 -> primaryReadValid 1 cycle later, data 0xDEADBEEF.
- Mask 0x3 write of 0x11223344 over 0xDEADBEEF -> read returns 0xDEAD3344.
- Same cycle: primary read addr 0x040, secondary read addr 0x100 (different banks) -> both valid on the next cycle; secondaryReady held at 1.
- Primary writes continuously to bank 0 while secondary reads addr 0x003 -> secondary captured into pending, forced through after 3 lost cycles. On the 4th cycle primaryReady = 0; secondary data returned and reflects prior writes.
- rst asserted while pending is valid and a read is in flight -> no valid strobe; outputs 0 and both Ready = 1 on the next cycle.
- With SRAM_WRAPPER_OUTPUT_REG_EN defined, repeat the first scenario -> valid appears 2 cycles after issue.

Source files
------------

// File: rtl/sram_wrapper_dff_rw_r_pkg.sv
// rtl/sram_wrapper_dff_rw_r_pkg.sv - shared sizing helpers for the banked two-port DFF SRAM wrapper
package sram_wrapper_dff_rw_r_pkg;

  localparam int STALL_W = 4;

  function automatic int word_size(input int byte_count);
    return 8 * byte_count;
  endfunction

  function automatic int bank_count(input int address_size, input int bank_address_size);
    return 1 << (address_size - bank_address_size);
  endfunction

  // Upper address bits above one macro's word range select the bank.
  function automatic int unsigned bank_index(input logic [31:0] addr, input int unsigned bank_address_size);
    return addr >> bank_address_size;
  endfunction

endpackage

// File: rtl/sram_wrapper_dff_rw_r_dff_ram_bank.sv
// rtl/sram_wrapper_dff_rw_r_dff_ram_bank.sv - one single-port DFF RAM macro, byte writes, 1-cycle read
module dff_ram_bank
  import sram_wrapper_dff_rw_r_pkg::*;
#(
  parameter int BYTE_COUNT = 4,
  parameter int ADDR_W     = 6,
  localparam int WORD_W    = word_size(BYTE_COUNT)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_COUNT-1:0] wmask,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [1 << ADDR_W];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  // Read output holds its last value so an idle bank does not disturb the mux.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int i = 0; i < BYTE_COUNT; i++) begin
        if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_wrapper_dff_rw_r.sv
// rtl/sram_wrapper_dff_rw_r.sv - banked two-port (RW + RO) DFF SRAM wrapper with conflict arbitration
// Optional output register stage: define SRAM_WRAPPER_OUTPUT_REG_EN for 2-cycle read latency.
module sram_wrapper_dff_rw_r
  import sram_wrapper_dff_rw_r_pkg::*;
#(
  parameter int BYTE_COUNT        = 4,
  parameter int ADDRESS_SIZE      = 9,
  parameter int BANK_ADDRESS_SIZE = 6,
  parameter int STALL_LIMIT       = 3,
  localparam int WORD_SIZE        = word_size(BYTE_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    primarySelect,
  input  logic                    primaryWriteEnable,
  input  logic [BYTE_COUNT-1:0]   primaryWriteMask,
  input  logic [ADDRESS_SIZE-1:0] primaryAddress,
  input  logic [WORD_SIZE-1:0]    primaryDataWrite,
  output logic                    primaryReady,
  output logic [WORD_SIZE-1:0]    primaryDataRead,
  output logic                    primaryReadValid,
  input  logic                    secondarySelect,
  input  logic [ADDRESS_SIZE-1:0] secondaryAddress,
  output logic                    secondaryReady,
  output logic [WORD_SIZE-1:0]    secondaryDataRead,
  output logic                    secondaryReadValid
);

  localparam int BANK_COUNT = bank_count(ADDRESS_SIZE, BANK_ADDRESS_SIZE);
  localparam int BIDX_W     = (ADDRESS_SIZE > BANK_ADDRESS_SIZE) ? ADDRESS_SIZE - BANK_ADDRESS_SIZE : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic                    pend_valid_q, pend_valid_d;
  logic [ADDRESS_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                    p_rvalid_q, p_rvalid_d;
  logic                    s_rvalid_q, s_rvalid_d;
  logic [BIDX_W-1:0]       p_bank_q, p_bank_d;
  logic [BIDX_W-1:0]       s_bank_q, s_bank_d;
  logic [WORD_SIZE-1:0]    p_hold_q, p_hold_d;
  logic [WORD_SIZE-1:0]    s_hold_q, s_hold_d;

  logic                    sec_valid;
  logic [ADDRESS_SIZE-1:0] sec_addr;
  logic [BIDX_W-1:0]       p_bidx, s_bidx;
  logic                    conflict, force_pend;
  logic                    p_issue, p_access, s_issue, capture;

  logic                    bank_en    [BANK_COUNT];
  logic                    bank_we    [BANK_COUNT];
  logic [BYTE_COUNT-1:0]   bank_mask  [BANK_COUNT];
  logic [BANK_ADDRESS_SIZE-1:0] bank_addr [BANK_COUNT];
  logic [WORD_SIZE-1:0]    bank_wdata [BANK_COUNT];
  logic [WORD_SIZE-1:0]    bank_rdata [BANK_COUNT];

  logic                    p_core_valid, s_core_valid;
  logic [WORD_SIZE-1:0]    p_core_data, s_core_data;

  // A pending entry always takes precedence over the live secondary request.
  always_comb begin
    sec_valid  = pend_valid_q || secondarySelect;
    sec_addr   = pend_valid_q ? pend_addr_q : secondaryAddress;
    p_bidx     = BIDX_W'(bank_index(32'(primaryAddress), BANK_ADDRESS_SIZE));
    s_bidx     = BIDX_W'(bank_index(32'(sec_addr), BANK_ADDRESS_SIZE));
    conflict   = primarySelect && sec_valid && (p_bidx == s_bidx);
    force_pend = pend_valid_q && (stall_cnt_q == STALL_MAX);
    p_issue    = !rst && primarySelect && !force_pend;
    p_access   = p_issue && (!primaryWriteEnable || (|primaryWriteMask));
    s_issue    = !rst && sec_valid && (!conflict || force_pend);
    capture    = !rst && secondarySelect && !pend_valid_q && conflict;
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    stall_cnt_d  = stall_cnt_q;
    if (capture) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = secondaryAddress;
    end else if (pend_valid_q && s_issue) begin
      pend_valid_d = 1'b0;
    end
    if (pend_valid_q && s_issue) begin
      stall_cnt_d = '0;
    end else if (conflict && !rst) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    p_rvalid_d = p_issue && !primaryWriteEnable;
    p_bank_d   = p_rvalid_d ? p_bidx : p_bank_q;
    s_rvalid_d = s_issue;
    s_bank_d   = s_issue ? s_bidx : s_bank_q;

    p_core_valid = p_rvalid_q;
    s_core_valid = s_rvalid_q;
    p_core_data  = p_rvalid_q ? bank_rdata[p_bank_q] : p_hold_q;
    s_core_data  = s_rvalid_q ? bank_rdata[s_bank_q] : s_hold_q;
    p_hold_d     = p_core_data;
    s_hold_d     = s_core_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      stall_cnt_q  <= '0;
      p_rvalid_q   <= 1'b0;
      s_rvalid_q   <= 1'b0;
      p_bank_q     <= '0;
      s_bank_q     <= '0;
      p_hold_q     <= '0;
      s_hold_q     <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      stall_cnt_q  <= stall_cnt_d;
      p_rvalid_q   <= p_rvalid_d;
      s_rvalid_q   <= s_rvalid_d;
      p_bank_q     <= p_bank_d;
      s_bank_q     <= s_bank_d;
      p_hold_q     <= p_hold_d;
      s_hold_q     <= s_hold_d;
    end
  end

  // Ports only share a bank on a forced pending issue, where primary is held off.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_en[b]    = 1'b0;
      bank_we[b]    = 1'b0;
      bank_mask[b]  = '0;
      bank_addr[b]  = '0;
      bank_wdata[b] = '0;
      if (s_issue && (s_bidx == BIDX_W'(b))) begin
        bank_en[b]   = 1'b1;
        bank_addr[b] = sec_addr[BANK_ADDRESS_SIZE-1:0];
      end else if (p_access && (p_bidx == BIDX_W'(b))) begin
        bank_en[b]    = 1'b1;
        bank_we[b]    = primaryWriteEnable;
        bank_mask[b]  = primaryWriteMask;
        bank_addr[b]  = primaryAddress[BANK_ADDRESS_SIZE-1:0];
        bank_wdata[b] = primaryDataWrite;
      end
    end
  end

  for (genvar g = 0; g < BANK_COUNT; g++) begin : g_bank
    dff_ram_bank #(
      .BYTE_COUNT(BYTE_COUNT),
      .ADDR_W    (BANK_ADDRESS_SIZE)
    ) u_bank (
      .clk  (clk),
      .en   (bank_en[g]),
      .we   (bank_we[g]),
      .wmask(bank_mask[g]),
      .addr (bank_addr[g]),
      .wdata(bank_wdata[g]),
      .rdata(bank_rdata[g])
    );
  end

  assign primaryReady   = !force_pend;
  assign secondaryReady = !pend_valid_q;

`ifdef SRAM_WRAPPER_OUTPUT_REG_EN
  logic                 p_out_valid_q, p_out_valid_d;
  logic                 s_out_valid_q, s_out_valid_d;
  logic [WORD_SIZE-1:0] p_out_data_q, p_out_data_d;
  logic [WORD_SIZE-1:0] s_out_data_q, s_out_data_d;

  always_comb begin
    p_out_valid_d = p_core_valid;
    s_out_valid_d = s_core_valid;
    p_out_data_d  = p_core_data;
    s_out_data_d  = s_core_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_out_valid_q <= 1'b0;
      s_out_valid_q <= 1'b0;
      p_out_data_q  <= '0;
      s_out_data_q  <= '0;
    end else begin
      p_out_valid_q <= p_out_valid_d;
      s_out_valid_q <= s_out_valid_d;
      p_out_data_q  <= p_out_data_d;
      s_out_data_q  <= s_out_data_d;
    end
  end

  assign primaryReadValid   = p_out_valid_q;
  assign secondaryReadValid = s_out_valid_q;
  assign primaryDataRead    = p_out_data_q;
  assign secondaryDataRead  = s_out_data_q;
`else
  assign primaryReadValid   = p_core_valid;
  assign secondaryReadValid = s_core_valid;
  assign primaryDataRead    = p_core_data;
  assign secondaryDataRead  = s_core_data;
`endif

endmodule

// File: tb/tb_sram_wrapper_dff_rw_r.sv
// tb/tb_sram_wrapper_dff_rw_r.sv - scoreboard bench for sram_wrapper_dff_rw_r
// Honours SRAM_WRAPPER_OUTPUT_REG_EN for the expected read latency.
module tb_sram_wrapper_dff_rw_r;

`ifdef SRAM_WRAPPER_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        primarySelect;
  logic        primaryWriteEnable;
  logic [3:0]  primaryWriteMask;
  logic [8:0]  primaryAddress;
  logic [31:0] primaryDataWrite;
  logic        primaryReady;
  logic [31:0] primaryDataRead;
  logic        primaryReadValid;
  logic        secondarySelect;
  logic [8:0]  secondaryAddress;
  logic        secondaryReady;
  logic [31:0] secondaryDataRead;
  logic        secondaryReadValid;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t p_q[$];
  exp_t s_q[$];

  sram_wrapper_dff_rw_r dut (
    .clk               (clk),
    .rst               (rst),
    .primarySelect     (primarySelect),
    .primaryWriteEnable(primaryWriteEnable),
    .primaryWriteMask  (primaryWriteMask),
    .primaryAddress    (primaryAddress),
    .primaryDataWrite  (primaryDataWrite),
    .primaryReady      (primaryReady),
    .primaryDataRead   (primaryDataRead),
    .primaryReadValid  (primaryReadValid),
    .secondarySelect   (secondarySelect),
    .secondaryAddress  (secondaryAddress),
    .secondaryReady    (secondaryReady),
    .secondaryDataRead (secondaryDataRead),
    .secondaryReadValid(secondaryReadValid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every read strobe must match the oldest expectation, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (primaryReadValid) begin
      vectors++;
      if (p_q.size() == 0) begin
        miscompares++;
        $display("FAIL p_unexpected_strobe cyc=%0d data=%h", cyc, primaryDataRead);
      end else begin
        e = p_q.pop_front();
        if (primaryDataRead !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL p_read got=%h@%0d want=%h@%0d", primaryDataRead, cyc, e.data, e.due);
        end
      end
    end
    if (secondaryReadValid) begin
      vectors++;
      if (s_q.size() == 0) begin
        miscompares++;
        $display("FAIL s_unexpected_strobe cyc=%0d data=%h", cyc, secondaryDataRead);
      end else begin
        e = s_q.pop_front();
        if (secondaryDataRead !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL s_read got=%h@%0d want=%h@%0d", secondaryDataRead, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    primarySelect = 1'b0;
    primaryWriteEnable = 1'b0;
    primaryWriteMask = 4'h0;
    secondarySelect = 1'b0;
  endtask

  task automatic pw(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    primarySelect = 1'b1;
    primaryWriteEnable = 1'b1;
    primaryWriteMask = m;
    primaryAddress = a;
    primaryDataWrite = d;
    tick();
    idle();
  endtask

  task automatic pr(input logic [8:0] a, input logic [31:0] exp);
    primarySelect = 1'b1;
    primaryWriteEnable = 1'b0;
    primaryAddress = a;
    p_q.push_back('{exp, cyc + LAT});
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    primaryAddress = '0;
    primaryDataWrite = '0;
    secondaryAddress = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pready", 32'(primaryReady), 32'd1);
    chk("rst_sready", 32'(secondaryReady), 32'd1);
    chk("rst_pdata", primaryDataRead, 32'h0);
    chk("rst_sdata", secondaryDataRead, 32'h0);
    tick();

    // Full write then read back; byte-masked merge; zero mask is a no-op.
    pw(9'h005, 32'hDEADBEEF, 4'hF);
    pr(9'h005, 32'hDEADBEEF);
    pw(9'h005, 32'h11223344, 4'h3);
    pr(9'h005, 32'hDEAD3344);
    pw(9'h005, 32'h00000000, 4'h0);
    pr(9'h005, 32'hDEAD3344);
    repeat (3) tick();
    chk("p_hold", primaryDataRead, 32'hDEAD3344);

    // Different banks in the same cycle, then back-to-back on both ports.
    pw(9'h040, 32'h40404040, 4'hF);
    pw(9'h100, 32'h01000100, 4'hF);
    primarySelect = 1'b1;
    primaryWriteEnable = 1'b0;
    primaryAddress = 9'h040;
    secondarySelect = 1'b1;
    secondaryAddress = 9'h100;
    p_q.push_back('{32'h40404040, cyc + LAT});
    s_q.push_back('{32'h01000100, cyc + LAT});
    @(negedge clk);
    chk("sready_dual", 32'(secondaryReady), 32'd1);
    tick();
    primaryAddress = 9'h005;
    secondaryAddress = 9'h040;
    p_q.push_back('{32'hDEAD3344, cyc + LAT});
    s_q.push_back('{32'h40404040, cyc + LAT});
    @(negedge clk);
    chk("sready_b2b", 32'(secondaryReady), 32'd1);
    tick();
    idle();
    tick();
    tick();

    // Bank-0 write stream starves a secondary read until it is forced through.
    primarySelect = 1'b1;
    primaryWriteEnable = 1'b1;
    primaryWriteMask = 4'hF;
    primaryAddress = 9'h003;
    primaryDataWrite = 32'hCAFE0001;
    secondarySelect = 1'b1;
    secondaryAddress = 9'h003;
    @(negedge clk);
    chk("starve_pready0", 32'(primaryReady), 32'd1);
    chk("starve_sready0", 32'(secondaryReady), 32'd1);
    tick();
    secondarySelect = 1'b0;
    primaryDataWrite = 32'hCAFE0002;
    @(negedge clk);
    chk("starve_pready1", 32'(primaryReady), 32'd1);
    chk("starve_sready1", 32'(secondaryReady), 32'd0);
    tick();
    primaryDataWrite = 32'hCAFE0003;
    @(negedge clk);
    chk("starve_pready2", 32'(primaryReady), 32'd1);
    tick();
    primaryDataWrite = 32'hCAFE0004;
    s_q.push_back('{32'hCAFE0003, cyc + LAT});
    @(negedge clk);
    chk("starve_pready3", 32'(primaryReady), 32'd0);
    chk("starve_sready3", 32'(secondaryReady), 32'd0);
    tick();
    @(negedge clk);
    chk("starve_pready4", 32'(primaryReady), 32'd1);
    chk("starve_sready4", 32'(secondaryReady), 32'd1);
    tick();
    idle();
    pr(9'h003, 32'hCAFE0004);
    tick();
    tick();

    // Reset with a pending secondary read and a primary read in flight.
    primarySelect = 1'b1;
    primaryWriteEnable = 1'b0;
    primaryAddress = 9'h005;
    secondarySelect = 1'b1;
    secondaryAddress = 9'h010;
    if (LAT == 1) p_q.push_back('{32'hDEAD3344, cyc + LAT});
    tick();
    rst = 1'b1;
    primaryAddress = 9'h040;
    secondarySelect = 1'b0;
    @(negedge clk);
    chk("pend_before_rst", 32'(secondaryReady), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_pready", 32'(primaryReady), 32'd1);
    chk("post_rst_sready", 32'(secondaryReady), 32'd1);
    chk("post_rst_pvalid", 32'(primaryReadValid), 32'd0);
    chk("post_rst_svalid", 32'(secondaryReadValid), 32'd0);
    chk("post_rst_pdata", primaryDataRead, 32'h0);
    chk("post_rst_sdata", secondaryDataRead, 32'h0);
    repeat (4) tick();

    // Memory contents survive reset.
    pr(9'h005, 32'hDEAD3344);
    repeat (4) tick();

    chk("p_queue_drained", 32'(p_q.size()), 32'd0);
    chk("s_queue_drained", 32'(s_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d limit=2000", cyc);
    $fatal(1, "timeout");
  end

endmodule
